// File: rtl/mrsc_pkg.sv
// MRSC 16/32 codec definitions: widths, syndrome struct and codeword helpers.
// Codeword bit c0 is the MSB of a lane slice; matrices are indexed [row][col].
package mrsc_pkg;
  localparam int MRSC_CW_W = 32;
  localparam int MRSC_DW   = 16;

  typedef logic [3:0][3:0] mrsc_mat_t;

  typedef struct packed {
    logic [3:0][1:0] l;
    logic [3:0]      sp;
    logic [3:0]      sd;
  } mrsc_syn_t;

  // s[r][j] = c[r+4j]
  function automatic mrsc_mat_t mrsc_matrix(input logic [MRSC_CW_W-1:0] cw);
    logic [MRSC_CW_W-1:0] c;
    mrsc_mat_t            m;
    c = {<<{cw}};
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        m[r][j] = c[r+4*j];
      end
    end
    return m;
  endfunction

  function automatic mrsc_syn_t mrsc_syndrome(input logic [MRSC_CW_W-1:0] cw);
    logic [MRSC_CW_W-1:0] c;
    mrsc_syn_t            syn;
    c = {<<{cw}};
    for (int r = 0; r < 4; r++) begin
      syn.l[r][0] = c[r]   ^ c[r+8]  ^ c[24+2*r];
      syn.l[r][1] = c[r+4] ^ c[r+12] ^ c[25+2*r];
    end
    // Column check bits are not stored in column order.
    syn.sp[0] = ^c[3:0]   ^ c[20];
    syn.sp[1] = ^c[7:4]   ^ c[22];
    syn.sp[2] = ^c[11:8]  ^ c[23];
    syn.sp[3] = ^c[15:12] ^ c[21];
    syn.sd[0] = c[0]  ^ c[5]  ^ c[2]  ^ c[7]  ^ c[16];
    syn.sd[1] = c[4]  ^ c[1]  ^ c[6]  ^ c[3]  ^ c[18];
    syn.sd[2] = c[8]  ^ c[13] ^ c[10] ^ c[15] ^ c[19];
    syn.sd[3] = c[12] ^ c[9]  ^ c[14] ^ c[11] ^ c[17];
    return syn;
  endfunction
endpackage

// File: rtl/mrsc_lane_corr.sv
// Combinational single-lane MRSC correction from raw matrix and syndromes.
// Emits transposed data (d[4r+j] = s[r][j]); raw data when correction is off.
module mrsc_lane_corr
  import mrsc_pkg::*;
(
  input  mrsc_mat_t          mat,
  input  mrsc_syn_t          syn,
  input  logic               correct_en,
  output logic [MRSC_DW-1:0] data,
  output logic               corr
);
  logic               fix_en;
  logic [2:0]         q1;
  logic [2:0]         q2;
  mrsc_mat_t          fix;
  logic [MRSC_DW-1:0] d_fix;
  logic [MRSC_DW-1:0] d_raw;

  always_comb begin
    fix_en = ((syn.sp != 4'd0) && (syn.sd != 4'd0)) || ($countones(syn.l) > 1);
    q1 = 3'(syn.sp[0]) + 3'(syn.sp[1]) + 3'(syn.sd[0]) + 3'(syn.sd[1]);
    q2 = 3'(syn.sp[2]) + 3'(syn.sp[3]) + 3'(syn.sd[2]) + 3'(syn.sd[3]);
    fix = mat;
    if (fix_en) begin
      for (int r = 0; r < 4; r++) begin
        if (q1 > q2) begin
          fix[r][0] = mat[r][0] ^ syn.l[r][0];
          fix[r][1] = mat[r][1] ^ syn.l[r][1];
        end else if (q1 < q2) begin
          fix[r][2] = mat[r][2] ^ syn.l[r][0];
          fix[r][3] = mat[r][3] ^ syn.l[r][1];
        end else if ({syn.sp[1:0], syn.sd[1:0]} != 4'd0) begin
          fix[r][1] = mat[r][1] ^ syn.l[r][1];
          fix[r][2] = mat[r][2] ^ syn.l[r][0];
        end
      end
    end
    d_fix = '0;
    d_raw = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        d_fix[MRSC_DW-1-(4*r+j)] = fix[r][j];
        d_raw[MRSC_DW-1-(4*r+j)] = mat[r][j];
      end
    end
    corr = correct_en && (d_fix != d_raw);
    data = correct_en ? d_fix : d_raw;
  end
endmodule

// File: rtl/mrsc_decoder_pipe.sv
// Multi-lane MRSC 16/32 decoder, 2-cycle latency, 1 beat/cycle, valid/ready.
// Both stages hold under out_ready=0; in_ready drops once S1 and S2 are full.
module mrsc_decoder_pipe
  import mrsc_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MRSC_CW_W*LANES-1:0] in_data,
  input  logic                       cfg_correct_en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MRSC_DW*LANES-1:0]   out_data,
  output logic [LANES-1:0]           out_syn_nz,
  output logic [LANES-1:0]           out_corr,
  input  logic                       cnt_clear,
  output logic [CNT_W-1:0]           cnt_err,
  output logic [CNT_W-1:0]           cnt_corr
);
  localparam int               SUM_W   = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  mrsc_mat_t          in_mat      [LANES];
  mrsc_syn_t          in_syn      [LANES];
  mrsc_mat_t          s1_mat      [LANES];
  mrsc_syn_t          s1_syn      [LANES];
  logic [MRSC_DW-1:0] lane_data   [LANES];
  logic               lane_corr   [LANES];
  logic               lane_syn_nz [LANES];
  logic               s1_vld;
  logic               s1_cfg;
  logic               s2_adv;
  logic               out_fire;
  logic [SUM_W-1:0]   err_sum;
  logic [SUM_W-1:0]   corr_sum;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_vld || s2_adv;
  assign out_fire = out_valid && out_ready;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [MRSC_CW_W-1:0] cw;
    assign cw             = in_data[MRSC_CW_W*n +: MRSC_CW_W];
    assign in_mat[n]      = mrsc_matrix(cw);
    assign in_syn[n]      = mrsc_syndrome(cw);
    assign lane_syn_nz[n] = |s1_syn[n];

    mrsc_lane_corr u_corr (
      .mat        (s1_mat[n]),
      .syn        (s1_syn[n]),
      .correct_en (s1_cfg),
      .data       (lane_data[n]),
      .corr       (lane_corr[n])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_cfg <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        s1_mat[n] <= '0;
        s1_syn[n] <= '0;
      end
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_cfg <= cfg_correct_en;
        for (int n = 0; n < LANES; n++) begin
          s1_mat[n] <= in_mat[n];
          s1_syn[n] <= in_syn[n];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_syn_nz <= '0;
      out_corr   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        for (int n = 0; n < LANES; n++) begin
          out_data[MRSC_DW*n +: MRSC_DW] <= lane_data[n];
          out_syn_nz[n]                  <= lane_syn_nz[n];
          out_corr[n]                    <= lane_corr[n];
        end
      end
    end
  end

  // Sums are wide enough for a full beat of flags on top of a saturated count.
  assign err_sum  = SUM_W'(cnt_err)  + SUM_W'($countones(out_syn_nz));
  assign corr_sum = SUM_W'(cnt_corr) + SUM_W'($countones(out_corr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_err  <= '0;
      cnt_corr <= '0;
    end else if (cnt_clear) begin
      cnt_err  <= '0;
      cnt_corr <= '0;
    end else if (out_fire) begin
      cnt_err  <= (err_sum  > CNT_MAX) ? '1 : err_sum[CNT_W-1:0];
      cnt_corr <= (corr_sum > CNT_MAX) ? '1 : corr_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_mrsc_decoder_pipe.sv
// Directed bench for mrsc_decoder_pipe: a 1-lane/2-bit-counter instance and a
// 4-lane instance sharing clock and reset.
`timescale 1ns/1ps
module tb_mrsc_decoder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_cfg, a_out_valid, a_out_ready, a_cnt_clear;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [0:0]  a_syn_nz, a_corr;
  logic [1:0]  a_cnt_err, a_cnt_corr;

  logic         b_in_valid, b_in_ready, b_cfg, b_out_valid, b_out_ready, b_cnt_clear;
  logic [127:0] b_in_data;
  logic [63:0]  b_out_data;
  logic [3:0]   b_syn_nz, b_corr;
  logic [15:0]  b_cnt_err, b_cnt_corr;

  int checks = 0;
  int fails  = 0;

  // Valid codewords and their decoded data (c0 = bit 31, d0 = bit 15).
  logic [31:0] cw_tab [5] = '{32'h00000000, 32'hFFFF0000, 32'h80008880, 32'h08002240, 32'h40002820};
  logic [15:0] dw_tab [5] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h4000, 16'h0800};

  mrsc_decoder_pipe #(.LANES(1), .CNT_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .cfg_correct_en(a_cfg), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_syn_nz(a_syn_nz), .out_corr(a_corr), .cnt_clear(a_cnt_clear), .cnt_err(a_cnt_err),
    .cnt_corr(a_cnt_corr)
  );

  mrsc_decoder_pipe #(.LANES(4), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .cfg_correct_en(b_cfg), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_syn_nz(b_syn_nz), .out_corr(b_corr), .cnt_clear(b_cnt_clear), .cnt_err(b_cnt_err),
    .cnt_corr(b_cnt_corr)
  );

  function automatic logic [127:0] beat_in(input int b);
    logic [127:0] v;
    for (int l = 0; l < 4; l++) v[32*l +: 32] = cw_tab[(b + l) % 5];
    return v;
  endfunction

  function automatic logic [63:0] beat_out(input int b);
    logic [63:0] v;
    for (int l = 0; l < 4; l++) v[16*l +: 16] = dw_tab[(b + l) % 5];
    return v;
  endfunction

  // One beat through instance a; returns what appeared and after how many cycles.
  task automatic send1(input logic [31:0] cw, input logic en, output logic [15:0] d,
                       output logic syn, output logic corr, output int lat);
    a_in_valid = 1'b1; a_in_data = cw; a_cfg = en; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 99; d = '0; syn = 1'b0; corr = 1'b0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (a_out_valid) begin
        lat = k; d = a_out_data; syn = a_syn_nz[0]; corr = a_corr[0];
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_cfg = 1; a_out_ready = 1; a_cnt_clear = 0;
    b_in_valid = 0; b_in_data = '0; b_cfg = 1; b_out_ready = 1; b_cnt_clear = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready, a_out_data, a_syn_nz, a_corr, a_cnt_err, a_cnt_corr} !== {1'b0, 1'b1, 22'h0}) begin
      fails++;
      $display("FAIL reset_a: got v=%b r=%b d=%h e=%0d c=%0d want v=0 r=1 d=0000 e=0 c=0",
               a_out_valid, a_in_ready, a_out_data, a_cnt_err, a_cnt_corr);
    end
    checks++;
    if ({b_out_valid, b_in_ready, b_out_data, b_syn_nz, b_corr, b_cnt_err, b_cnt_corr} !== {1'b0, 1'b1, 104'h0}) begin
      fails++;
      $display("FAIL reset_b: got v=%b r=%b d=%h e=%0d c=%0d want v=0 r=1 d=0 e=0 c=0",
               b_out_valid, b_in_ready, b_out_data, b_cnt_err, b_cnt_corr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    logic [15:0] d; logic syn, corr; int lat;
    for (int i = 0; i < 5; i++) begin
      send1(cw_tab[i], 1'b1, d, syn, corr, lat);
      checks++;
      if ({d, syn, corr} !== {dw_tab[i], 2'b00}) begin
        fails++;
        $display("FAIL clean_%0d: got d=%h syn=%b corr=%b want d=%h syn=0 corr=0", i, d, syn, corr, dw_tab[i]);
      end
      checks++;
      if (lat != 2) begin
        fails++;
        $display("FAIL latency_%0d: got %0d cycles want 2", i, lat);
      end
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== 4'b0000) begin
      fails++;
      $display("FAIL clean_counters: got err=%0d corr=%0d want 0 0", a_cnt_err, a_cnt_corr);
    end
  endtask

  task automatic test_single_flip;
    logic [15:0] d; logic syn, corr; int lat;
    send1(32'h80000000, 1'b1, d, syn, corr, lat);  // c0 flipped: q1 > q2 branch
    checks++;
    if ({d, syn, corr} !== {16'h0000, 2'b11}) begin
      fails++;
      $display("FAIL flip_c0: got d=%h syn=%b corr=%b want d=0000 syn=1 corr=1", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd1, 2'd1}) begin
      fails++;
      $display("FAIL flip_c0_counters: got err=%0d corr=%0d want 1 1", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
    send1(32'h00800000, 1'b1, d, syn, corr, lat);  // c8 flipped: q1 < q2 branch
    checks++;
    if ({d, syn, corr} !== {16'h0000, 2'b11}) begin
      fails++;
      $display("FAIL flip_c8: got d=%h syn=%b corr=%b want d=0000 syn=1 corr=1", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd2, 2'd2}) begin
      fails++;
      $display("FAIL flip_c8_counters: got err=%0d corr=%0d want 2 2", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_check_only;
    logic [15:0] d; logic syn, corr; int lat;
    send1(32'h00000800, 1'b1, d, syn, corr, lat);  // c20 only: correction not enabled
    checks++;
    if ({d, syn, corr} !== {16'h0000, 2'b10}) begin
      fails++;
      $display("FAIL flip_c20: got d=%h syn=%b corr=%b want d=0000 syn=1 corr=0", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd3, 2'd2}) begin
      fails++;
      $display("FAIL flip_c20_counters: got err=%0d corr=%0d want 3 2", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_detect_only;
    logic [15:0] d; logic syn, corr; int lat;
    send1(32'h80000000, 1'b0, d, syn, corr, lat);
    checks++;
    if ({d, syn, corr} !== {16'h8000, 2'b10}) begin
      fails++;
      $display("FAIL detect_c0: got d=%h syn=%b corr=%b want d=8000 syn=1 corr=0", d, syn, corr);
    end
    send1(32'h00800000, 1'b0, d, syn, corr, lat);
    checks++;
    if ({d, syn, corr} !== {16'h2000, 2'b10}) begin
      fails++;
      $display("FAIL detect_c8: got d=%h syn=%b corr=%b want d=2000 syn=1 corr=0", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd3, 2'd2}) begin
      fails++;
      $display("FAIL detect_counters: got err=%0d corr=%0d want 3 2", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie_break;
    logic [15:0] d; logic syn, corr; int lat;
    // c16,c19,c20,c23,c24 flipped: q1 == q2 == 2, L00 = 1 lands on s[0][2]
    send1(32'h00009980, 1'b1, d, syn, corr, lat);
    checks++;
    if ({d, syn, corr} !== {16'h2000, 2'b11}) begin
      fails++;
      $display("FAIL tie_break: got d=%h syn=%b corr=%b want d=2000 syn=1 corr=1", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd3, 2'd3}) begin
      fails++;
      $display("FAIL tie_counters: got err=%0d corr=%0d want 3 3", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    logic [15:0] d; logic syn, corr; int lat;
    send1(32'h7FFF0000, 1'b1, d, syn, corr, lat);
    checks++;
    if ({d, syn, corr} !== {16'hFFFF, 2'b11}) begin
      fails++;
      $display("FAIL flip_ones_c0: got d=%h syn=%b corr=%b want d=ffff syn=1 corr=1", d, syn, corr);
    end
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd3, 2'd3}) begin
      fails++;
      $display("FAIL saturation: got err=%0d corr=%0d want 3 3", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_clear;
    logic [15:0] d; logic syn, corr; int lat;
    a_in_valid = 1'b1; a_in_data = 32'h80000000; a_cfg = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    a_cnt_clear = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_syn_nz} !== 2'b11) begin
      fails++;
      $display("FAIL clear_beat_present: got v=%b syn=%b want 1 1", a_out_valid, a_syn_nz);
    end
    @(posedge clk); #1;
    a_cnt_clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== 4'b0000) begin
      fails++;
      $display("FAIL clear_priority: got err=%0d corr=%0d want 0 0", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
    send1(32'h80000000, 1'b1, d, syn, corr, lat);
    @(negedge clk);
    checks++;
    if ({a_cnt_err, a_cnt_corr} !== {2'd1, 2'd1}) begin
      fails++;
      $display("FAIL count_after_clear: got err=%0d corr=%0d want 1 1", a_cnt_err, a_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int sent, rcv;
    logic stalled;
    logic [63:0] held;
    sent = 0; rcv = 0; stalled = 1'b0; held = '0;
    b_cfg = 1'b1;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      b_out_ready = (cyc >= 5);
      b_in_valid  = (sent < 6);
      b_in_data   = beat_in(sent);
      @(negedge clk);
      if (cyc == 4) begin
        checks++;
        if (b_in_ready !== 1'b0 || sent != 2 || b_out_valid !== 1'b1) begin
          fails++;
          $display("FAIL stall_in_ready: got in_ready=%b accepted=%0d out_valid=%b want 0 2 1",
                   b_in_ready, sent, b_out_valid);
        end
      end
      if (stalled) begin
        checks++;
        if (b_out_data !== held) begin
          fails++;
          $display("FAIL stall_hold: got %h want %h", b_out_data, held);
        end
      end
      stalled = b_out_valid && !b_out_ready;
      held    = b_out_data;
      if (b_out_valid && b_out_ready) begin
        checks++;
        if ({b_out_data, b_syn_nz, b_corr} !== {beat_out(rcv), 8'h00}) begin
          fails++;
          $display("FAIL beat_%0d: got d=%h syn=%b corr=%b want d=%h syn=0000 corr=0000",
                   rcv, b_out_data, b_syn_nz, b_corr, beat_out(rcv));
        end
        rcv++;
      end
      if (b_in_valid && b_in_ready) sent++;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    checks++;
    if (rcv != 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d beats want 6", rcv);
    end
    @(negedge clk);
    checks++;
    if ({b_cnt_err, b_cnt_corr} !== 32'h0) begin
      fails++;
      $display("FAIL b2b_counters: got err=%0d corr=%0d want 0 0", b_cnt_err, b_cnt_corr);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream;
    int stale;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = beat_in(7);
    repeat (3) @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    checks++;
    if (b_out_valid !== 1'b1) begin
      fails++;
      $display("FAIL midstream_loaded: got out_valid=%b want 1", b_out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({b_out_valid, b_in_ready, b_out_data} !== {1'b0, 1'b1, 64'h0}) begin
      fails++;
      $display("FAIL async_reset: got v=%b r=%b d=%h want v=0 r=1 d=0", b_out_valid, b_in_ready, b_out_data);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    b_out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      fails++;
      $display("FAIL stale_after_reset: got %0d valid cycles want 0", stale);
    end
    checks++;
    if ({a_cnt_err, a_cnt_corr, b_cnt_err, b_cnt_corr} !== 36'h0) begin
      fails++;
      $display("FAIL counters_after_reset: got a=%0d/%0d b=%0d/%0d want all 0",
               a_cnt_err, a_cnt_corr, b_cnt_err, b_cnt_corr);
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_single_flip;
    test_check_only;
    test_detect_only;
    test_tie_break;
    test_saturation;
    test_cnt_clear;
    test_back_to_back;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
